// File: rtl/lc3_execute_pipe.sv
// LC-3 execute stage: ALU, condition codes, address adder and
// registered write-back/memory controls behind a valid/ready handshake.
//
// Ports:
//   clock, reset (async, active-low), enable_execute (global gate),
//   flush (sync drop of all transactions)
//   in_valid/in_ready: upstream handshake
//   out_valid/out_ready: downstream handshake
//   E_Control, IR, npc, VSR1, VSR2: operands and decoded controls
//   W_Control_in/out, Mem_Control_in/out: pass-through controls
//   sr1, sr2: combinational source register indices
//   aluout, pcout, M_Data, carry, NZP, dr: registered results
module lc3_execute_pipe #(
  parameter int DATA_W = 16,
  parameter bit SKID   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_execute,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        E_Control,
  input  logic [15:0]       IR,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] VSR1,
  input  logic [DATA_W-1:0] VSR2,
  input  logic [1:0]        W_Control_in,
  input  logic              Mem_Control_in,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] aluout,
  output logic [DATA_W-1:0] pcout,
  output logic [DATA_W-1:0] M_Data,
  output logic              carry,
  output logic [2:0]        NZP,
  output logic [2:0]        dr,
  output logic [1:0]        W_Control_out,
  output logic              Mem_Control_out
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] md;
    logic              c;
    logic [2:0]        nzp;
    logic [2:0]        dr;
    logic [1:0]        wc;
    logic              mc;
  } res_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [DATA_W-1:0] off11;
  logic [DATA_W-1:0] off9;
  logic [DATA_W-1:0] off6;
  logic [DATA_W-1:0] imm5;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] addr2;
  logic [DATA_W:0]   sum;
  res_t              res_c;

  state_t state_q, state_d;
  res_t   out_q, out_d;
  res_t   skid_q, skid_d;
  logic   ov_q, ov_d;
  logic   stall;
  logic   unused_ir;

  assign unused_ir = ^IR[15:14];

  assign sr1 = IR[8:6];

  always_comb begin
    unique case (IR[13:12])
      2'b01:   sr2 = IR[2:0];
      2'b11:   sr2 = IR[11:9];
      default: sr2 = 3'd0;
    endcase
  end

  always_comb begin
    off11 = {{(DATA_W-11){IR[10]}}, IR[10:0]};
    off9  = {{(DATA_W-9){IR[8]}}, IR[8:0]};
    off6  = {{(DATA_W-6){IR[5]}}, IR[5:0]};
    imm5  = {{(DATA_W-5){IR[4]}}, IR[4:0]};
    opb   = E_Control[0] ? VSR2 : imm5;
    sum   = {1'b0, VSR1} + {1'b0, opb};
    res_c = '0;

    unique case (E_Control[5:4])
      2'b00: begin
        res_c.alu = sum[DATA_W-1:0];
        res_c.c   = sum[DATA_W];
      end
      2'b01:   res_c.alu = VSR1 & opb;
      2'b10:   res_c.alu = ~VSR1;
      default: res_c.alu = VSR1;
    endcase

    unique case (E_Control[3:2])
      2'b00:   addr1 = off11;
      2'b01:   addr1 = off9;
      2'b10:   addr1 = off6;
      default: addr1 = '0;
    endcase
    addr2    = E_Control[1] ? npc : VSR1;
    res_c.pc = addr1 + addr2;

    unique case (1'b1)
      res_c.alu[DATA_W-1]: res_c.nzp = 3'b100;
      (res_c.alu == '0):   res_c.nzp = 3'b010;
      default:             res_c.nzp = 3'b001;
    endcase

    unique case (IR[13:12])
      2'b01, 2'b10: res_c.dr = IR[11:9];
      default:      res_c.dr = 3'd0;
    endcase

    res_c.md = VSR2;
    res_c.wc = W_Control_in;
    res_c.mc = Mem_Control_in;
  end

  // Without a skid, ready follows the downstream slot combinationally.
  assign in_ready = SKID ? (state_q == EMPTY)
                         : (!ov_q || out_ready);

  assign stall = ov_q && !out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    ov_d    = ov_q;
    if (enable_execute) begin
      if (flush) begin
        ov_d    = 1'b0;
        state_d = EMPTY;
      end else if (state_q == FULL) begin
        // Output is always valid while the skid holds an entry.
        if (out_ready) begin
          out_d   = skid_q;
          state_d = EMPTY;
        end
      end else if (in_valid && in_ready) begin
        if (stall && SKID) begin
          skid_d  = res_c;
          state_d = FULL;
        end else begin
          out_d = res_c;
          ov_d  = 1'b1;
        end
      end else if (out_ready) begin
        ov_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      ov_q    <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_valid       = ov_q;
  assign aluout          = out_q.alu;
  assign pcout           = out_q.pc;
  assign M_Data          = out_q.md;
  assign carry           = out_q.c;
  assign NZP             = out_q.nzp;
  assign dr              = out_q.dr;
  assign W_Control_out   = out_q.wc;
  assign Mem_Control_out = out_q.mc;

endmodule

// File: tb/tb_lc3_execute_pipe.sv
// Bench for lc3_execute_pipe: 16-bit skid instance plus a 32-bit
// no-skid instance, checked against a queue-based reference model.
module tb_lc3_execute_pipe;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] pc;
    logic [63:0] md;
    logic        c;
    logic [2:0]  nzp;
    logic [2:0]  dr;
    logic [1:0]  wc;
    logic        mc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [5:0]  ectl;
  logic [15:0] ir;
  logic [15:0] npc16, a16, b16;
  logic [31:0] npc32, a32, b32;
  logic [1:0]  wc;
  logic        mc;

  logic        in_ready;
  logic [2:0]  sr1, sr2;
  logic        out_valid;
  logic [15:0] aluout, pcout, mdata;
  logic        carry;
  logic [2:0]  nzp, dr;
  logic [1:0]  wco;
  logic        mco;

  logic        in_ready32;
  logic [2:0]  sr1_32, sr2_32;
  logic        ov32;
  logic [31:0] alu32, pc32, md32;
  logic        c32;
  logic [2:0]  nzp32, dr32;
  logic [1:0]  wco32;
  logic        mco32;
  logic        or32;

  int   n_chk;
  int   n_fail;
  exp_t q[$];
  exp_t e32;
  bit   v32;

  lc3_execute_pipe #(.DATA_W(16), .SKID(1'b1)) u16 (
    .clock(clk), .reset(rst_n),
    .enable_execute(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .E_Control(ectl), .IR(ir), .npc(npc16),
    .VSR1(a16), .VSR2(b16),
    .W_Control_in(wc), .Mem_Control_in(mc),
    .sr1(sr1), .sr2(sr2),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluout(aluout), .pcout(pcout), .M_Data(mdata),
    .carry(carry), .NZP(nzp), .dr(dr),
    .W_Control_out(wco), .Mem_Control_out(mco)
  );

  lc3_execute_pipe #(.DATA_W(32), .SKID(1'b0)) u32 (
    .clock(clk), .reset(rst_n),
    .enable_execute(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .E_Control(ectl), .IR(ir), .npc(npc32),
    .VSR1(a32), .VSR2(b32),
    .W_Control_in(wc), .Mem_Control_in(mc),
    .sr1(sr1_32), .sr2(sr2_32),
    .out_valid(ov32), .out_ready(or32),
    .aluout(alu32), .pcout(pc32), .M_Data(md32),
    .carry(c32), .NZP(nzp32), .dr(dr32),
    .W_Control_out(wco32), .Mem_Control_out(mco32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input int          w,
    input logic [5:0]  ec,
    input logic [15:0] iw,
    input logic [63:0] np,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [1:0]  wci,
    input logic        mci
  );
    exp_t        e;
    logic [63:0] mask, opb, sum, ad1, ad2;
    longint      t11, t9, t6, t5;
    mask = (64'd1 << w) - 64'd1;
    t11  = $signed(iw[10:0]);
    t9   = $signed(iw[8:0]);
    t6   = $signed(iw[5:0]);
    t5   = $signed(iw[4:0]);
    opb  = ec[0] ? b : (64'(t5) & mask);
    e.c  = 1'b0;
    case (ec[5:4])
      2'd0: begin
        sum   = a + opb;
        e.alu = sum & mask;
        e.c   = sum[w];
      end
      2'd1:    e.alu = a & opb;
      2'd2:    e.alu = ~a & mask;
      default: e.alu = a;
    endcase
    case (ec[3:2])
      2'd0:    ad1 = 64'(t11);
      2'd1:    ad1 = 64'(t9);
      2'd2:    ad1 = 64'(t6);
      default: ad1 = 64'd0;
    endcase
    ad2  = ec[1] ? np : a;
    e.pc = (ad1 + ad2) & mask;
    if (e.alu[w-1])        e.nzp = 3'b100;
    else if (e.alu == 0)   e.nzp = 3'b010;
    else                   e.nzp = 3'b001;
    if (iw[13:12] == 2'd1 || iw[13:12] == 2'd2)
      e.dr = iw[11:9];
    else
      e.dr = 3'd0;
    e.md = b;
    e.wc = wci;
    e.mc = mci;
    return e;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] expv
  );
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic cmp16(input exp_t e);
    chk("alu16", 64'(aluout), e.alu);
    chk("pc16", 64'(pcout), e.pc);
    chk("md16", 64'(mdata), e.md);
    chk("carry16", 64'(carry), 64'(e.c));
    chk("nzp16", 64'(nzp), 64'(e.nzp));
    chk("dr16", 64'(dr), 64'(e.dr));
    chk("wc16", 64'(wco), 64'(e.wc));
    chk("mc16", 64'(mco), 64'(e.mc));
  endtask

  task automatic cmp32(input exp_t e);
    chk("alu32", 64'(alu32), e.alu);
    chk("pc32", 64'(pc32), e.pc);
    chk("carry32", 64'(c32), 64'(e.c));
    chk("nzp32", 64'(nzp32), 64'(e.nzp));
  endtask

  // One clock: check handshake state against the queue model,
  // account for drain/accept/flush, then cross the rising edge.
  task automatic step();
    bit         acc, drn;
    logic [2:0] esr2;
    #1;
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("sr1", 64'(sr1), 64'(ir[8:6]));
    if (ir[13:12] == 2'd1)      esr2 = ir[2:0];
    else if (ir[13:12] == 2'd3) esr2 = ir[11:9];
    else                        esr2 = 3'd0;
    chk("sr2", 64'(sr2), 64'(esr2));
    acc = in_valid && q.size() < 2 && en && !flush;
    drn = q.size() != 0 && out_ready && en && !flush;
    if (drn) begin
      cmp16(q[0]);
      void'(q.pop_front());
    end
    if (acc)
      q.push_back(model(16, ectl, ir, 64'(npc16),
                        64'(a16), 64'(b16), wc, mc));
    if (en && flush) q.delete();

    chk("in_ready32", 64'(in_ready32), 64'd1);
    chk("out_valid32", 64'(ov32), 64'(v32));
    if (v32) cmp32(e32);
    if (en) begin
      if (flush) v32 = 1'b0;
      else if (in_valid) begin
        e32 = model(32, ectl, ir, 64'(npc32),
                    64'(a32), 64'(b32), wc, mc);
        v32 = 1'b1;
      end else v32 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    v32       = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    or32      = 1'b1;
    ectl      = '0;
    ir        = '0;
    npc16     = '0;
    a16       = '0;
    b16       = '0;
    npc32     = 32'h0001_0000;
    a32       = 32'h1234_5678;
    b32       = 32'h0000_0010;
    wc        = '0;
    mc        = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu", 64'(aluout), 64'd0);
    chk("rst_pc", 64'(pcout), 64'd0);
    chk("rst_nzp", 64'(nzp), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_dr", 64'(dr), 64'd0);
    chk("rst_wc", 64'(wco), 64'd0);
    chk("rst_mc", 64'(mco), 64'd0);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD register form
    in_valid = 1'b1;
    ectl     = 6'b00_11_0_1;
    ir       = 16'h1042;
    a16      = 16'h0005;
    b16      = 16'hFFFB;
    wc       = 2'b10;
    mc       = 1'b1;
    step();
    chk("add_alu", 64'(aluout), 64'h0000);
    chk("add_carry", 64'(carry), 64'd1);
    chk("add_nzp", 64'(nzp), 64'b010);
    chk("add_dr", 64'(dr), 64'd0);
    chk("add_pc", 64'(pcout), 64'h0005);
    chk("add_wc", 64'(wco), 64'b10);

    // PC-relative branch target
    ectl  = 6'b11_01_1_0;
    ir    = 16'h0FFE;
    npc16 = 16'h3000;
    wc    = 2'b00;
    mc    = 1'b0;
    step();
    chk("br_pc", 64'(pcout), 64'h2FFE);
    chk("br_carry", 64'(carry), 64'd0);

    // NOT on the 32-bit instance
    ectl = 6'b10_11_0_0;
    ir   = 16'h0000;
    a32  = 32'h0000_0000;
    step();
    chk("not32_alu", 64'(alu32), 64'hFFFF_FFFF);
    chk("not32_nzp", 64'(nzp32), 64'b100);

    in_valid = 1'b0;
    step();

    // Backpressure: A, B, C with two stalled cycles
    ectl      = 6'b11_11_0_1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a16       = 16'h000A;
    step();
    chk("bp_a_alu", 64'(aluout), 64'h000A);
    a16 = 16'h000B;
    step();
    chk("bp_skid_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_a", 64'(aluout), 64'h000A);
    a16 = 16'h000C;
    step();
    chk("bp_c_held", 64'(in_ready), 64'd0);
    chk("bp_still_a", 64'(aluout), 64'h000A);
    out_ready = 1'b1;
    step();
    chk("bp_b_alu", 64'(aluout), 64'h000B);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("bp_c_alu", 64'(aluout), 64'h000C);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush with a concurrent accept
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a16       = 16'h0101;
    step();
    a16 = 16'h0202;
    step();
    flush = 1'b1;
    a16   = 16'h7777;
    step();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("fl_never_out", 64'(out_valid), 64'd0);

    // Asynchronous reset while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ectl      = 6'b11_00_1_1;
    a16       = 16'h8001;
    npc16     = 16'h4000;
    step();
    a16 = 16'h0033;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_nzp", 64'(nzp), 64'd0);
    chk("ar_pc", 64'(pcout), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    v32 = 1'b0;
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom % 8) != 0;
      flush     = en && (($urandom % 16) == 0);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      ectl      = 6'($urandom);
      ir        = 16'($urandom);
      npc16     = 16'($urandom);
      a16       = 16'($urandom);
      b16       = 16'($urandom);
      npc32     = $urandom;
      a32       = $urandom;
      b32       = $urandom;
      wc        = 2'($urandom);
      mc        = 1'($urandom);
      step();
    end

    en        = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("end_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_execute_pipe.md
# lc3_execute_pipe

Parametrised execute stage for the LC-3 pipeline, successor to the fixed 16-bit execute block. It sits between decode and memory access, computes the ALU result, condition codes and the PC-relative/base address, and registers the write-back and memory controls. It adds a valid/ready handshake with an optional skid buffer, a synchronous flush, and a data width that is a parameter.

## Interface
- DATA_W, 16: width of register values, npc, aluout, pcout and M_Data; DATA_W ≥ 16.
- SKID, 1: 1 adds a one-entry skid buffer, making in_ready a pure register output; 0 has no buffer and makes in_ready combinational.
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_execute  in  1  global gate; when low, no state changes, and in_ready/out_valid hold their values.
- flush  in  1  synchronous; drops every held and incoming transaction.
- in_valid  in  1  upstream holds a transaction.
- in_ready  out  1  stage accepts this cycle.
- E_Control  in  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- IR  in  16  instruction word; always 16 bits regardless of DATA_W.
- npc  in  DATA_W  PC+1 of the instruction.
- VSR1, VSR2  in  DATA_W  source register values.
- W_Control_in  in  2  write-back control, passed through.
- Mem_Control_in  in  1  memory control, passed through.
- sr1, sr2  out  3  combinational source register indices decoded from IR.
- out_valid  out  1  output registers hold a transaction.
- out_ready  in  1  downstream accepts.
- aluout, pcout, M_Data  out  DATA_W  registered results.
- carry  out  1  carry out of ADD; 0 for the other ALU operations.
- NZP  out  3  registered condition code {N,Z,P}.
- dr  out  3  destination register index.
- W_Control_out  out  2  registered pass-through of W_Control_in.
- Mem_Control_out  out  1  registered pass-through of Mem_Control_in.

## Operation
- Immediate fields, each sign-extended to DATA_W:
  - offset11 = IR[10:0]
  - offset9 = IR[8:0]
  - offset6 = IR[5:0]
  - imm5 = IR[4:0]
- ALU operand B is VSR2 when op2select=1, otherwise imm5. Operand A is always VSR1.
- alu_control selects the operation:
  - 00: ADD, A+B mod 2^DATA_W, carry = bit DATA_W of the sum.
  - 01: AND.
  - 10: NOT A.
  - 11: pass A.
- Address adder: pcout = addrin1 + addrin2 mod 2^DATA_W.
  - addrin1 by pcselect1: 0 → offset11, 1 → offset9, 2 → offset6, 3 → 0.
  - addrin2 = npc when pcselect2=1, else VSR1.
- NZP is computed from the ALU result and is always one-hot:
  - 100 when the MSB is 1.
  - 010 when the result is zero.
  - 001 otherwise.
- sr1 = IR[8:6].
- sr2 by IR[13:12]: 01 → IR[2:0], 11 → IR[11:9], otherwise 0.
- dr by IR[13:12]: 01 or 10 → IR[11:9], otherwise 0.
- M_Data captures VSR2.
- Skid control has two states:
  - EMPTY → FULL when the output is stalled (out_valid & !out_ready) and an input is accepted; the input is computed and parked in the skid.
  - FULL → EMPTY when the output drains (out_ready=1); the skid moves into the output registers.
- in_ready:
  - SKID=1: in_ready = skid EMPTY.
  - SKID=0: in_ready = !out_valid | out_ready.

## Timing
- Reset (reset=0, asynchronous):
  - Every output register clears to 0, including out_valid, NZP, carry, dr, W_Control_out, Mem_Control_out and skid state.
  - in_ready = 1 when SKID=1.
- Latency: a transaction accepted at edge k (in_valid & in_ready & enable_execute) appears with out_valid=1 after edge k.
- Throughput: 1 transaction per cycle while out_ready=1.
- Output registers change only on a handshake, or when empty and loading. They stay stable while out_valid & !out_ready.
- Stall ordering: a transaction parked in the skid is presented only after the one ahead of it in the output registers has been accepted. Order is always preserved.
- flush=1 at an edge:
  - out_valid and the skid clear.
  - The concurrent input is dropped even if in_valid & in_ready. Flush wins over accept.
  - Data registers may keep stale values.
- enable_execute=0: the handshake is frozen. No acceptance and no drain occur, even if out_ready=1.
- Reset asserted mid-stall discards all held transactions immediately.

## Test plan
- ADD register form: VSR1=0x0005, VSR2=0xFFFB, E_Control=6'b00_11_0_1, IR=0x1042 → after 1 cycle: aluout=0x0000, carry=1, NZP=010, dr=0, sr2=2.
- Branch address: npc=0x3000, IR=0x0FFE (offset9=-2), pcselect1=1, pcselect2=1 → pcout=0x2FFE.
- NOT with NZP and DATA_W=32: VSR1=0x0000_0000, alu_control=10 → aluout=0xFFFF_FFFF, NZP=100.
- Backpressure (SKID=1): stream A, B, C with out_ready=0 for 2 cycles.
  - B lands in the skid and in_ready drops.
  - C is held upstream.
  - After out_ready=1, outputs appear in order A, B, C with no loss or duplication.
- Flush with simultaneous accept: out_valid=1, skid FULL, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the input is never output.
- Asynchronous reset pulse between clock edges while stalled → out_valid, NZP and pcout read 0 before the next edge; in_ready=1.
